gpio_7seg_scan: RTL and testbench

//  Parametrised 7-segment output port for the CPU's memory-mapped GPIO.
//  - Latches a hex word from the data-memory read bus on ena.
//  - Drives N_DIGITS digits two ways at once:
//    - static: all digits decoded in parallel on DOUT.
//    - scanned: one digit at a time on SEG/AN for boards with shared segment lines.
//  - Adds leading-zero blanking, blink mode, a load flag and synchronous reset.

---
 rtl/gpio_7seg_scan.sv | 81 ++++++++
 tb/tb_gpio_7seg_scan.sv | 115 +++++++++++
 2 files changed

// File: rtl/gpio_7seg_scan.sv
// gpio_7seg_scan: latched hex word driven as static 7-seg digits and as a multiplexed scan, with blanking and blink
module gpio_7seg_scan #(
  parameter int N_DIGITS    = 3,
  parameter int SCAN_DIV    = 1000,
  parameter int BLINK_DIV   = 2**22,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  ena,
  input  logic [4*N_DIGITS-1:0] din,
  input  logic [1:0]            mode,
  output logic [7*N_DIGITS-1:0] DOUT,
  output logic [6:0]            SEG,
  output logic [N_DIGITS-1:0]   AN,
  output logic                  loaded
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [4*N_DIGITS-1:0] data_q;
  logic [1:0]            mode_q;
  logic                  loaded_q, phase, on, nz, scan_wrap, blink_wrap;
  logic [SW-1:0]         scan_cnt;
  logic [BW-1:0]         blink_cnt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [N_DIGITS-1:0]   shown, an_nxt;
  logic [7*N_DIGITS-1:0] dout_nxt;
  logic [3:0]            sel_digit;
  logic [6:0]            seg_nxt;
  // Leading-zero blanking walks from the MSD down; digit 0 always forces "non-zero seen"
  always_comb begin
    on = loaded_q & ~(mode_q[1] & phase);
    nz = 1'b0;
    shown = '0;
    dout_nxt = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nz = nz | (data_q[4*k +: 4] != 4'h0) | (k == 0);
      shown[k] = on & (nz | ~mode_q[0]);
      dout_nxt[7*k +: 7] = {7{SEG_ACT_LOW}} ^ (shown[k] ? LUT[data_q[4*k +: 4]] : 7'h00);
    end
  end
  assign scan_wrap  = scan_cnt == SW'(SCAN_DIV - 1);
  assign blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
  assign idx_nxt    = !scan_wrap ? idx : (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
  // SEG/AN are registered from the next index so AN moves on the same edge as the wrap
  assign sel_digit  = 4'(data_q >> {idx_nxt, 2'b00});
  assign seg_nxt    = {7{SEG_ACT_LOW}} ^ (1'(shown >> idx_nxt) ? LUT[sel_digit] : 7'h00);
  assign an_nxt     = {N_DIGITS{AN_ACT_LOW}} ^ (on ? N_DIGITS'(1) << idx_nxt : '0);
  assign loaded     = loaded_q;
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      data_q    <= '0;
      mode_q    <= 2'b00;
      loaded_q  <= 1'b0;
      scan_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      DOUT      <= {7*N_DIGITS{SEG_ACT_LOW}};
      SEG       <= {7{SEG_ACT_LOW}};
      AN        <= {N_DIGITS{AN_ACT_LOW}};
    end else begin
      if (ena) begin
        data_q   <= din;
        mode_q   <= mode;
        loaded_q <= 1'b1;
      end
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
      idx       <= idx_nxt;
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      phase     <= phase ^ blink_wrap;
      DOUT      <= dout_nxt;
      SEG       <= seg_nxt;
      AN        <= an_nxt;
    end
  end
endmodule

// File: tb/tb_gpio_7seg_scan.sv
// tb_gpio_7seg_scan: directed checks of static decode, blanking, blink, reset and scan timing
module tb_gpio_7seg_scan;
  logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic [11:0] din = '0;
  logic [1:0]  mode = '0;
  logic [20:0] dout;
  logic [6:0]  seg;
  logic [2:0]  an, prev_an;
  logic [20:0] prev_dout;
  logic        loaded, found;
  int          checks = 0, errors = 0;
  logic [2:0]  an_seq  [3] = '{3'b110, 3'b101, 3'b011};
  logic [6:0]  seg_a   [3] = '{7'h6D, 7'h77, 7'h06};
  logic [6:0]  seg_b   [3] = '{7'h07, 7'h7C, 7'h5B};

  gpio_7seg_scan #(.N_DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(8), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b1)) dut (
    .CLK(clk), .RST_n(rst_n), .ena(ena), .din(din), .mode(mode),
    .DOUT(dout), .SEG(seg), .AN(an), .loaded(loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] d, input logic [1:0] m);
    ena = 1'b1; din = d; mode = m;
    tick;
    ena = 1'b0;
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_dout", dout, 0); chk("rst_seg", seg, 0); chk("rst_an", an, 3'b111); chk("rst_loaded", loaded, 0);
    rst_n = 1'b1;
    // T1: idle after reset stays blank
    for (int i = 0; i < 40; i++) begin
      tick;
      chk("t1_dout", dout, 0); chk("t1_seg", seg, 0); chk("t1_an", an, 3'b111); chk("t1_loaded", loaded, 0);
    end
    // T2: plain hex write and scan sequence
    wr(12'h1A5, 2'b00);
    chk("t2_loaded", loaded, 1);
    tick;
    chk("t2_dout", dout, {7'h06, 7'h77, 7'h6D});
    found = 1'b0;
    prev_an = an;
    for (int i = 0; i < 20 && !found; i++) begin
      tick;
      if (an == 3'b110 && prev_an != 3'b110) found = 1'b1;
      prev_an = an;
    end
    chk("t2_sync", found, 1);
    for (int i = 0; i < 12; i++) begin
      chk("t2_an", an, an_seq[i/4]);
      chk("t2_seg", seg, seg_a[i/4]);
      tick;
    end
    // T3: leading-zero blanking
    wr(12'h005, 2'b01); tick; chk("t3_005", dout, {7'h00, 7'h00, 7'h6D});
    wr(12'h000, 2'b01); tick; chk("t3_000", dout, {7'h00, 7'h00, 7'h3F});
    wr(12'h050, 2'b01); tick; chk("t3_050", dout, {7'h00, 7'h6D, 7'h3F});
    wr(12'h000, 2'b00); tick; chk("t3_nolzb", dout, {7'h3F, 7'h3F, 7'h3F});
    // T4: blink, 8 cycles lit then 8 blank
    wr(12'h888, 2'b10); tick;
    found = 1'b0;
    prev_dout = dout;
    for (int i = 0; i < 20 && !found; i++) begin
      tick;
      if (prev_dout == 0 && dout != 0) found = 1'b1;
      prev_dout = dout;
    end
    chk("t4_sync", found, 1);
    for (int i = 0; i < 24; i++) begin
      if (i / 8 == 1) begin
        chk("t4_dout_off", dout, 0);
        chk("t4_an_off", an, 3'b111);
      end else begin
        chk("t4_dout_on", dout, {7'h7F, 7'h7F, 7'h7F});
      end
      tick;
    end
    // T5: reset mid-scan beats a simultaneous write
    wr(12'h1A5, 2'b00);
    repeat (5) tick;
    rst_n = 1'b0; ena = 1'b1; din = 12'hFFF; mode = 2'b00;
    tick;
    chk("t5_dout", dout, 0); chk("t5_seg", seg, 0); chk("t5_an", an, 3'b111); chk("t5_loaded", loaded, 0);
    rst_n = 1'b1; din = 12'h1A5;
    tick;
    ena = 1'b0;
    chk("t5_an1", an, 3'b111); chk("t5_loaded1", loaded, 1);
    // T5/T6: scan restarts at digit 0; write lands on the wrap edge 12
    for (int e = 2; e <= 20; e++) begin
      if (e == 12) begin ena = 1'b1; din = 12'h2B7; end
      tick;
      ena = 1'b0;
      chk("t56_an", an, an_seq[(e/4)%3]);
      chk("t56_seg", seg, e <= 12 ? seg_a[(e/4)%3] : seg_b[(e/4)%3]);
      if (e == 13) chk("t6_dout", dout, {7'h5B, 7'h7C, 7'h07});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
